// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Bits needed to count 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bi, with borrow-out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bin, one bit per clock, LSB first,
// with a start/ready/valid handshake around a single full-subtractor cell.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d, diff_q, diff_d;
    logic             brw_q, brw_d, bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fs_d, fs_bo;

    full_subtractor u_fs (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .bi (brw_q),
        .d  (fs_d),
        .bo (fs_bo)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new start directly, giving WIDTH+1 throughput.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {fs_d, res_q[WIDTH-1:1]};
                brw_d = fs_bo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = {fs_d, res_q[WIDTH-1:1]};
                    bout_d  = fs_bo;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign ready = (state_q != SHIFT);
    assign valid = (state_q == DONE);
    assign diff  = diff_q;
    assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       ready;
    logic       valid;
    logic [3:0] diff;
    logic       bout;

    int compared;
    int mismatched;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .valid (valid),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation from idle, check ready low through SHIFT and the result.
    task automatic run_one(input logic [3:0] ta, input logic [3:0] tb_, input logic tbin,
                           input logic [3:0] ediff, input logic ebout, input string tag);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_ready_busy"}, 32'(ready), 32'd0);
            chk({tag, "_valid_early"}, 32'(valid), 32'd0);
        end
        step();
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_diff"}, 32'(diff), 32'(ediff));
        chk({tag, "_bout"}, 32'(bout), 32'(ebout));
        chk({tag, "_ready_done"}, 32'(ready), 32'd1);
        step();
        chk({tag, "_valid_pulse"}, 32'(valid), 32'd0);
        chk({tag, "_diff_hold"}, 32'(diff), 32'(ediff));
    endtask

    initial begin
        logic [3:0] xa, xb;
        logic       xbin;
        int         idx;
        compared = 0;
        mismatched = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;

        step();
        step();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        step();

        run_one(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, "nobrw");
        run_one(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, "under");
        run_one(4'd5, 4'd5, 1'b1, 4'hF, 1'b1, "binonly");
        run_one(4'd0, 4'd0, 1'b0, 4'h0, 1'b0, "zero");

        // Start held with new operands during SHIFT: ignored, then accepted in DONE.
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        step();
        a = 4'd15; b = 4'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hs_ignored_ready", 32'(ready), 32'd0);
        end
        step();
        chk("hs_first_valid", 32'(valid), 32'd1);
        chk("hs_first_diff", 32'(diff), 32'd6);
        chk("hs_first_bout", 32'(bout), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hs_second_gap_valid", 32'(valid), 32'd0);
            chk("hs_second_gap_ready", 32'(ready), 32'd0);
            chk("hs_diff_hold", 32'(diff), 32'd6);
        end
        step();
        chk("hs_second_valid", 32'(valid), 32'd1);
        chk("hs_second_diff", 32'(diff), 32'hE);
        chk("hs_second_bout", 32'(bout), 32'd0);
        start = 1'b0;
        step();

        // Reset during the second SHIFT cycle, with start held to show reset dominates.
        a = 4'd3; b = 4'd9; bin = 1'b1; start = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("mrst_ready", 32'(ready), 32'd1);
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_diff", 32'(diff), 32'd0);
        chk("mrst_bout", 32'(bout), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        chk("mrst_ready_after", 32'(ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mrst_no_valid", 32'(valid), 32'd0);
            chk("mrst_diff_zero", 32'(diff), 32'd0);
        end

        // Exhaustive sweep, back to back: next operands queued while the current one shifts.
        idx = 0;
        {xa, xb, xbin} = 9'(idx);
        a = xa; b = xb; bin = xbin; start = 1'b1;
        step();
        for (int i = 0; i < 512; i++) begin
            logic [3:0] ea, eb;
            logic       ebin;
            logic [3:0] ediff;
            logic       ebout;
            {ea, eb, ebin} = 9'(i);
            ediff = ea - eb - {3'd0, ebin};
            ebout = (5'(ea) < (5'(eb) + 5'(ebin)));
            if (i < 511) begin
                {xa, xb, xbin} = 9'(i + 1);
                a = xa; b = xb; bin = xbin;
            end else begin
                start = 1'b0;
            end
            step();
            step();
            step();
            chk("ex_not_yet", 32'(valid), 32'd0);
            step();
            chk("ex_valid", 32'(valid), 32'd1);
            chk("ex_diff", 32'(diff), 32'(ediff));
            chk("ex_bout", 32'(bout), 32'(ebout));
            step();
        end
        chk("ex_idle_ready", 32'(ready), 32'd1);
        chk("ex_idle_valid", 32'(valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
